// File: rtl/div_multiciclo.sv
// Multicycle restoring signed divider for DIV: remainder -> hi_out, quotient -> lo_out.
// Define DIV_UNSIGNED_EN to add the unsigned_op input (DIVU).
module div_multiciclo #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
`ifdef DIV_UNSIGNED_EN
  input  logic             unsigned_op,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             done,
  output logic             div_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ITER,
    FIX,
    DONE
  } stateT;

  stateT state;
  stateT stateNext;

  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic             sa;
  logic             sb;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dsr;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             uop;

`ifdef DIV_UNSIGNED_EN
  assign uop = unsigned_op;
`else
  assign uop = 1'b0;
`endif

  // Trial subtract needs one extra bit: its MSB says whether it went negative.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {1'b0, dsr};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (start) stateNext = CHECK;
      CHECK:   stateNext = (bReg == '0) ? IDLE : ITER;
      ITER:    if (cnt == LAST) stateNext = FIX;
      FIX:     stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aReg     <= '0;
      bReg     <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      dsr      <= '0;
      cnt      <= '0;
      hi_out   <= '0;
      lo_out   <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      busy     <= (stateNext != IDLE);
      unique case (state)
        IDLE: begin
          if (start) begin
            aReg <= dividend;
            bReg <= divisor;
            sa   <= dividend[WIDTH-1] & ~uop;
            sb   <= divisor[WIDTH-1] & ~uop;
          end
        end
        CHECK: begin
          if (bReg == '0) begin
            div_zero <= 1'b1;
          end else begin
            quo <= sa ? -aReg : aReg;
            dsr <= sb ? -bReg : bReg;
            rem <= '0;
            cnt <= '0;
          end
        end
        ITER: begin
          if (trial[WIDTH]) begin
            rem <= shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end else begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          lo_out <= (sa ^ sb) ? -quo : quo;
          hi_out <= sa ? -rem : rem;
          done   <= 1'b1;
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_multiciclo.sv
// Scoreboard bench for div_multiciclo: driver pushes expected results,
// monitor pops and compares on every done/div_zero pulse.
module tb_div_multiciclo;

  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] hi_out;
  logic [W-1:0] lo_out;
  logic         done;
  logic         div_zero;
  logic         busy;

  div_multiciclo #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .hi_out(hi_out),
    .lo_out(lo_out),
    .done(done),
    .div_zero(div_zero),
    .busy(busy)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    bit           zero;
    int           cyc;
  } expT;

  expT sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [W-1:0] lastHi = '0;
  logic [W-1:0] lastLo = '0;
  bit prevDone = 0;

  initial clock = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic, truncating division.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output expT e);
    longint x;
    longint y;
    longint q;
    longint r;
    x = longint'($signed(a));
    y = longint'($signed(b));
    if (y == 0) begin
      e.zero = 1;
      e.hi = lastHi;
      e.lo = lastLo;
      e.cyc = cyc + 2;
    end else begin
      q = x / y;
      r = x % y;
      e.zero = 0;
      e.hi = r[W-1:0];
      e.lo = q[W-1:0];
      e.cyc = cyc + 35;
      lastHi = e.hi;
      lastLo = e.lo;
    end
  endtask

  always @(negedge clock) begin
    expT e;
    if (prevDone) begin
      chk("busy_after_done", {63'd0, busy}, 64'd0);
    end
    prevDone = done;
    if (done && div_zero) begin
      chk("done_and_zero", 64'd1, 64'd0);
    end
    if (done || div_zero) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {63'd0, done}, {63'd0, div_zero});
        chk("unexpected_pulse2", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("kind", {63'd0, div_zero}, {63'd0, e.zero});
        chk("latency", 64'(cyc), 64'(e.cyc));
        chk("hi", {32'd0, hi_out}, {32'd0, e.hi});
        chk("lo", {32'd0, lo_out}, {32'd0, e.lo});
      end
    end
  end

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (busy) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push);
    expT e;
    @(negedge clock);
    dividend = a;
    divisor = b;
    start = 1;
    model(a, b, e);
    if (push) sb.push_back(e);
    @(negedge clock);
    start = 0;
  endtask

  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b);
    issue(a, b, 1);
    waitIdle();
  endtask

  initial begin
    logic [W-1:0] pool [8];
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int n;
    pool[0] = 32'h8000_0000;
    pool[1] = 32'hFFFF_FFFF;
    pool[2] = 32'h0000_0001;
    pool[3] = 32'h7FFF_FFFF;
    pool[4] = 32'h0000_0000;
    pool[5] = 32'h0000_0003;
    pool[6] = 32'hFFFF_FFFD;
    pool[7] = 32'h0001_0000;
    reset = 1;
    start = 0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(negedge clock);
    chk("rst_hi", {32'd0, hi_out}, 64'd0);
    chk("rst_lo", {32'd0, lo_out}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_zero", {63'd0, div_zero}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    reset = 0;
    @(negedge clock);

    runOp(32'd7, 32'd2);
    runOp(32'hFFFF_FFF9, 32'd2);
    runOp(32'd7, 32'hFFFF_FFFE);
    runOp(32'd7, 32'd2);
    runOp(32'd1234, 32'd0);
    runOp(32'h8000_0000, 32'hFFFF_FFFF);

    // A second start mid-iteration must be ignored.
    issue(32'd100, 32'd7, 1);
    repeat (6) @(negedge clock);
    dividend = 32'd999;
    divisor = 32'd10;
    start = 1;
    @(negedge clock);
    start = 0;
    waitIdle();

    // Reset in the middle of iterating: no pulse, everything cleared.
    issue(32'd5000, 32'd3, 0);
    repeat (11) @(negedge clock);
    reset = 1;
    #1;
    chk("midrst_hi", {32'd0, hi_out}, 64'd0);
    chk("midrst_lo", {32'd0, lo_out}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    @(negedge clock);
    reset = 0;
    lastHi = '0;
    lastLo = '0;
    repeat (40) @(negedge clock);
    chk("post_rst_busy", {63'd0, busy}, 64'd0);

    for (int i = 0; i < 30; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 7)] : $urandom;
      case ($urandom_range(0, 3))
        0: rb = pool[$urandom_range(0, 7)];
        1: rb = $urandom_range(1, 20);
        2: rb = -$urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      runOp(ra, rb);
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("pending", 64'(sb.size()), 64'd0);
    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
